// File: rtl/debug_cmd_master.sv
// Debug bus command master: parses UART command frames, runs one register access, returns response bytes.
// Optional bus timeout when DBG_CMD_TIMEOUT_EN is defined.
module debug_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  dbg_a,
    output logic [15:0] dbg_di,
    input  logic [15:0] dbg_do,
    output logic        dbg_we,
    output logic        dbg_rd,
    input  logic        dbg_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DHI     = 3'd2,
        DLO     = 3'd3,
        BUS     = 3'd4,
        RESP_HI = 3'd5,
        RESP_LO = 3'd6
    } state_t;

    localparam logic [7:0] RSP_ACK     = 8'hA5;
    localparam logic [7:0] RSP_BAD_OP  = 8'hEF;
    localparam logic [7:0] RSP_TIMEOUT = 8'hEE;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t     state;
    logic       is_write;
    logic [7:0] rd_lo;
    logic       ovr;
    logic       tmo_stat;

`ifdef DBG_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt;
    logic             tmo;
    assign tmo_stat = tmo;
`else
    assign tmo_stat = 1'b0;
`endif

    // Bytes arriving while the bus access or response is in flight are dropped
    logic overrun;
    assign overrun = rx_valid && (state == BUS || state == RESP_HI || state == RESP_LO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_write <= 1'b0;
            rd_lo    <= 8'h00;
            ovr      <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            dbg_a    <= 8'h00;
            dbg_di   <= 16'h0000;
            dbg_we   <= 1'b0;
            dbg_rd   <= 1'b0;
            busy     <= 1'b0;
`ifdef DBG_CMD_TIMEOUT_EN
            cnt      <= '0;
            tmo      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        busy <= 1'b1;
                        case (rx_data)
                            8'h01: begin
                                is_write <= 1'b1;
                                state    <= ADDR;
                            end
                            8'h02: begin
                                is_write <= 1'b0;
                                state    <= ADDR;
                            end
                            8'h03: begin
                                tx_data  <= {6'b0, tmo_stat, ovr};
                                tx_valid <= 1'b1;
                                ovr      <= 1'b0;
`ifdef DBG_CMD_TIMEOUT_EN
                                tmo      <= 1'b0;
`endif
                                state    <= RESP_LO;
                            end
                            default: begin
                                tx_data  <= RSP_BAD_OP;
                                tx_valid <= 1'b1;
                                state    <= RESP_LO;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        dbg_a <= rx_data;
                        if (is_write) begin
                            state <= DHI;
                        end else begin
                            dbg_di <= 16'h0000;
                            dbg_rd <= 1'b1;
                            state  <= BUS;
`ifdef DBG_CMD_TIMEOUT_EN
                            cnt    <= '0;
`endif
                        end
                    end
                end
                DHI: begin
                    if (rx_valid) begin
                        dbg_di[15:8] <= rx_data;
                        state        <= DLO;
                    end
                end
                DLO: begin
                    if (rx_valid) begin
                        dbg_di[7:0] <= rx_data;
                        dbg_we      <= 1'b1;
                        state       <= BUS;
`ifdef DBG_CMD_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
                BUS: begin
                    if (dbg_ready) begin
                        dbg_we   <= 1'b0;
                        dbg_rd   <= 1'b0;
                        tx_valid <= 1'b1;
                        if (is_write) begin
                            tx_data <= RSP_ACK;
                            state   <= RESP_LO;
                        end else begin
                            tx_data <= dbg_do[15:8];
                            rd_lo   <= dbg_do[7:0];
                            state   <= RESP_HI;
                        end
                    end
`ifdef DBG_CMD_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dbg_we   <= 1'b0;
                        dbg_rd   <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_TIMEOUT;
                        tmo      <= 1'b1;
                        state    <= RESP_LO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                RESP_HI: begin
                    if (tx_ready) begin
                        tx_data <= rd_lo;
                        state   <= RESP_LO;
                    end
                end
                RESP_LO: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    dbg_we   <= 1'b0;
                    dbg_rd   <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase

            // Set wins over the status-read clear
            if (overrun) begin
                ovr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debug_cmd_master.sv
// Directed self-checking bench for debug_cmd_master (timeout scenario when DBG_CMD_TIMEOUT_EN is defined).
module tb_debug_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  dbg_a;
    logic [15:0] dbg_di;
    logic [15:0] dbg_do;
    logic        dbg_we;
    logic        dbg_rd;
    logic        dbg_ready;
    logic        busy;

    int runs = 0;
    int errs = 0;

    debug_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .dbg_a     (dbg_a),
        .dbg_di    (dbg_di),
        .dbg_do    (dbg_do),
        .dbg_we    (dbg_we),
        .dbg_rd    (dbg_rd),
        .dbg_ready (dbg_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the byte was sampled
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        runs++;
        if ({dbg_we, dbg_rd, tx_valid, busy} !== 4'b0000) begin
            errs++; $display("FAIL reset_ctl: got %b want 0000", {dbg_we, dbg_rd, tx_valid, busy});
        end
        runs++;
        if ({tx_data, dbg_a, dbg_di} !== 32'h0) begin
            errs++; $display("FAIL reset_data: got %h want 00000000", {tx_data, dbg_a, dbg_di});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        send_byte(8'h01); send_byte(8'h13); send_byte(8'hBE); send_byte(8'hEF);
        runs++;
        if ({dbg_we, dbg_rd, busy, dbg_a, dbg_di} !== {3'b101, 8'h13, 16'hBEEF}) begin
            errs++; $display("FAIL wr_start: got %h want %h", {dbg_we, dbg_rd, busy, dbg_a, dbg_di}, {3'b101, 8'h13, 16'hBEEF});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            runs++;
            if ({dbg_we, dbg_rd, tx_valid, dbg_a, dbg_di} !== {3'b100, 8'h13, 16'hBEEF}) begin
                errs++; $display("FAIL wr_hold%0d: got %h want %h", i, {dbg_we, dbg_rd, tx_valid, dbg_a, dbg_di}, {3'b100, 8'h13, 16'hBEEF});
            end
        end
        dbg_ready = 1'b1;
        @(negedge clk);
        dbg_ready = 1'b0;
        runs++;
        if ({dbg_we, tx_valid, tx_data} !== {2'b01, 8'hA5}) begin
            errs++; $display("FAIL wr_ack: got %h want %h", {dbg_we, tx_valid, tx_data}, {2'b01, 8'hA5});
        end
        @(negedge clk);
        runs++;
        if ({tx_valid, busy, tx_data} !== {2'b11, 8'hA5}) begin
            errs++; $display("FAIL wr_ack_hold: got %h want %h", {tx_valid, busy, tx_data}, {2'b11, 8'hA5});
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        runs++;
        if ({tx_valid, busy} !== 2'b00) begin
            errs++; $display("FAIL wr_done: got %b want 00", {tx_valid, busy});
        end
    endtask

    task automatic test_read();
        send_byte(8'h02); send_byte(8'h10);
        runs++;
        if ({dbg_we, dbg_rd, dbg_a, dbg_di} !== {2'b01, 8'h10, 16'h0000}) begin
            errs++; $display("FAIL rd_start: got %h want %h", {dbg_we, dbg_rd, dbg_a, dbg_di}, {2'b01, 8'h10, 16'h0000});
        end
        dbg_do = 16'h1234;
        repeat (5) @(negedge clk);
        runs++;
        if ({dbg_rd, tx_valid} !== 2'b10) begin
            errs++; $display("FAIL rd_wait: got %b want 10", {dbg_rd, tx_valid});
        end
        dbg_ready = 1'b1;
        @(negedge clk);
        dbg_ready = 1'b0;
        dbg_do    = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            runs++;
            if ({dbg_rd, tx_valid, tx_data} !== {2'b01, 8'h12}) begin
                errs++; $display("FAIL rd_hi%0d: got %h want %h", i, {dbg_rd, tx_valid, tx_data}, {2'b01, 8'h12});
            end
            @(negedge clk);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        runs++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h34}) begin
            errs++; $display("FAIL rd_lo: got %h want %h", {tx_valid, tx_data}, {1'b1, 8'h34});
        end
        @(negedge clk);
        tx_ready = 1'b0;
        runs++;
        if ({tx_valid, busy} !== 2'b00) begin
            errs++; $display("FAIL rd_done: got %b want 00", {tx_valid, busy});
        end
    endtask

    task automatic test_bad_opcode();
        send_byte(8'h7F);
        runs++;
        if ({tx_valid, busy, tx_data} !== {2'b11, 8'hEF}) begin
            errs++; $display("FAIL bad_resp: got %h want %h", {tx_valid, busy, tx_data}, {2'b11, 8'hEF});
        end
        tx_ready = 1'b1;
        @(negedge clk);
        runs++;
        if ({tx_valid, busy} !== 2'b00) begin
            errs++; $display("FAIL bad_idle: got %b want 00", {tx_valid, busy});
        end
        // Back-to-back read in the cycle after the handshake, ready tied high
        dbg_ready = 1'b1;
        dbg_do    = 16'hA55A;
        send_byte(8'h02); send_byte(8'h10);
        runs++;
        if ({dbg_rd, tx_valid, dbg_a} !== {2'b10, 8'h10}) begin
            errs++; $display("FAIL b2b_rd: got %h want %h", {dbg_rd, tx_valid, dbg_a}, {2'b10, 8'h10});
        end
        @(negedge clk);
        dbg_ready = 1'b0;
        runs++;
        if ({dbg_rd, tx_valid, tx_data} !== {2'b01, 8'hA5}) begin
            errs++; $display("FAIL b2b_hi: got %h want %h", {dbg_rd, tx_valid, tx_data}, {2'b01, 8'hA5});
        end
        @(negedge clk);
        runs++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin
            errs++; $display("FAIL b2b_lo: got %h want %h", {tx_valid, tx_data}, {1'b1, 8'h5A});
        end
        @(negedge clk);
        tx_ready = 1'b0;
        runs++;
        if ({tx_valid, busy} !== 2'b00) begin
            errs++; $display("FAIL b2b_done: got %b want 00", {tx_valid, busy});
        end
    endtask

    task automatic test_overrun();
        send_byte(8'h02); send_byte(8'h20);
        send_byte(8'h55);
        runs++;
        if ({dbg_rd, dbg_we, tx_valid, dbg_a} !== {3'b100, 8'h20}) begin
            errs++; $display("FAIL ovr_bus: got %h want %h", {dbg_rd, dbg_we, tx_valid, dbg_a}, {3'b100, 8'h20});
        end
        dbg_do    = 16'h0BCD;
        dbg_ready = 1'b1;
        tx_ready  = 1'b1;
        @(negedge clk);
        dbg_ready = 1'b0;
        runs++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h0B}) begin
            errs++; $display("FAIL ovr_rd: got %h want %h", {tx_valid, tx_data}, {1'b1, 8'h0B});
        end
        repeat (2) @(negedge clk);
        send_byte(8'h03);
        runs++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h01}) begin
            errs++; $display("FAIL ovr_stat1: got %h want %h", {tx_valid, tx_data}, {1'b1, 8'h01});
        end
        @(negedge clk);
        send_byte(8'h03);
        runs++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h00}) begin
            errs++; $display("FAIL ovr_stat2: got %h want %h", {tx_valid, tx_data}, {1'b1, 8'h00});
        end
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        send_byte(8'h02); send_byte(8'h05);
        n = 0;
        while (dbg_rd && n < 40) begin
            n++;
            @(negedge clk);
        end
`ifdef DBG_CMD_TIMEOUT_EN
        runs++;
        if (n !== 8) begin
            errs++; $display("FAIL tmo_len: got %0d cycles want 8", n);
        end
        runs++;
        if ({tx_valid, tx_data} !== {1'b1, 8'hEE}) begin
            errs++; $display("FAIL tmo_resp: got %h want %h", {tx_valid, tx_data}, {1'b1, 8'hEE});
        end
        tx_ready = 1'b1;
        @(negedge clk);
        send_byte(8'h03);
        runs++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h02}) begin
            errs++; $display("FAIL tmo_stat: got %h want %h", {tx_valid, tx_data}, {1'b1, 8'h02});
        end
`else
        runs++;
        if (n !== 40 || tx_valid !== 1'b0) begin
            errs++; $display("FAIL bus_wait: got %0d cycles tx_valid %b want 40 0", n, tx_valid);
        end
        dbg_do    = 16'h0000;
        dbg_ready = 1'b1;
        tx_ready  = 1'b1;
        @(negedge clk);
        dbg_ready = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h03);
        runs++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h00}) begin
            errs++; $display("FAIL notmo_stat: got %h want %h", {tx_valid, tx_data}, {1'b1, 8'h00});
        end
`endif
        @(negedge clk);
        tx_ready = 1'b0;
        runs++;
        if ({tx_valid, busy} !== 2'b00) begin
            errs++; $display("FAIL tmo_done: got %b want 00", {tx_valid, busy});
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h01); send_byte(8'h13);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        runs++;
        if ({busy, dbg_a, dbg_we} !== 10'h0) begin
            errs++; $display("FAIL rst_dhi: got %h want 000", {busy, dbg_a, dbg_we});
        end
        send_byte(8'h02); send_byte(8'h10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        runs++;
        if ({dbg_rd, busy, dbg_a} !== 10'h0) begin
            errs++; $display("FAIL rst_bus: got %h want 000", {dbg_rd, busy, dbg_a});
        end
        send_byte(8'h42);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        runs++;
        if ({tx_valid, tx_data} !== 9'h0) begin
            errs++; $display("FAIL rst_resp: got %h want 000", {tx_valid, tx_data});
        end
        dbg_ready = 1'b1;
        tx_ready  = 1'b1;
        send_byte(8'h01); send_byte(8'h13); send_byte(8'h00); send_byte(8'h01);
        runs++;
        if ({dbg_we, dbg_a, dbg_di} !== {1'b1, 8'h13, 16'h0001}) begin
            errs++; $display("FAIL rst_wr: got %h want %h", {dbg_we, dbg_a, dbg_di}, {1'b1, 8'h13, 16'h0001});
        end
        @(negedge clk);
        runs++;
        if ({dbg_we, tx_valid, tx_data} !== {2'b01, 8'hA5}) begin
            errs++; $display("FAIL rst_wr_ack: got %h want %h", {dbg_we, tx_valid, tx_data}, {2'b01, 8'hA5});
        end
        @(negedge clk);
        dbg_ready = 1'b0;
        tx_ready  = 1'b0;
        runs++;
        if ({tx_valid, busy} !== 2'b00) begin
            errs++; $display("FAIL rst_wr_done: got %b want 00", {tx_valid, busy});
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        dbg_do    = 16'h0000;
        dbg_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", runs, errs);
        $finish;
    end

endmodule

// File: doc/debug_cmd_master.md
# debug_cmd_master

Byte-stream command initiator for the debug control bus: parses command frames arriving from the debug UART receiver, drives the `dbg_a`/`dbg_di`/`dbg_we`/`dbg_rd` register interface until `dbg_ready`, and returns acknowledge, read data or error bytes to the UART transmitter. It sits between the UART byte layer and the debug register bank / QSPI debug window. It is the only master of that bus.

## Interface
- `TIMEOUT_CYCLES`, 1024: bus cycles to wait for `dbg_ready` before aborting; must be at least 2.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low; clock `clk`.
- `rx_data` in 8: received byte, valid when `rx_valid`=1.
- `rx_valid` in 1: one-cycle strobe per received byte; there is no back-pressure.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response byte available.
- `tx_ready` in 1: the transmitter accepts the byte when `tx_valid`&&`tx_ready`.
- `dbg_a` out 8: register address.
- `dbg_di` out 16: write data.
- `dbg_do` in 16: read data, sampled in the `dbg_ready` cycle.
- `dbg_we` out 1: write strobe, held until ready.
- `dbg_rd` out 1: read strobe, held until ready.
- `dbg_ready` in 1: access complete.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Frames, bytes in arrival order:
  - 0x01 write: address, data[15:8], data[7:0].
  - 0x02 read: address.
  - 0x03 status: opcode only.
- Any other opcode: the block responds 0xEF and returns to IDLE.
- States: IDLE, ADDR, DHI, DLO, BUS, RESP_HI, RESP_LO.
- Transitions:
  - IDLE: opcode 0x01/0x02 goes to ADDR; 0x03 loads the status byte and goes to RESP_LO.
  - ADDR: write goes to DHI; read goes to BUS.
  - DHI goes to DLO, then DLO goes to BUS.
  - BUS waits for ready.
  - Write completion goes to RESP_LO with 0xA5.
  - Read completion captures `dbg_do` and goes to RESP_HI, which sends data[15:8], then RESP_LO, which sends data[7:0].
  - RESP_LO returns to IDLE after its handshake.
- Bus rules:
  - In BUS, exactly one of `dbg_we`/`dbg_rd` is high.
  - `dbg_a` and `dbg_di` are stable for the whole BUS state.
  - `dbg_di`=0 during reads.
  - The strobe drops the cycle after `dbg_ready` is sampled high.
- Overrun: an `rx_valid` pulse seen while in BUS, RESP_HI or RESP_LO drops the byte and sets the sticky `ovr` flag. The frame in progress is unaffected.
- Status byte = {6'b0, `tmo`, `ovr`}.
  - Loading it clears both flags.
  - A set event in the same cycle as the clear wins.
- Reset values:
  - `tx_valid`, `dbg_we`, `dbg_rd`, `busy` = 0.
  - `tx_data`, `dbg_a`, `dbg_di` = 0.
  - Flags = 0; state = IDLE.
- Reset mid-operation: strobes and `tx_valid` drop on the reset cycle and the partial frame is discarded.

## Timing
- All outputs are registered.
- The final frame byte at cycle N gives a strobe high at N+1.
- `dbg_ready` high at cycle M gives:
  - strobe low at M+1;
  - `tx_valid` high at M+1 with the first response byte.
- `dbg_ready` is ignored outside BUS.
- `tx_valid`/`tx_data` hold until the handshake.
  - After a RESP_HI handshake, the next byte is valid on the following cycle.
  - After RESP_LO the block is back in IDLE; it accepts an opcode in the cycle after the handshake.
- Minimum write turnaround with `dbg_ready` tied high and `tx_ready` tied high: the strobe is high for 1 cycle.

## Configuration
- `DBG_CMD_TIMEOUT_EN` defined:
  - A counter reloads to 0 on BUS entry and increments each BUS cycle without ready.
  - When it reaches `TIMEOUT_CYCLES-1` with `dbg_ready` still low, the strobe drops next cycle, the response is 0xEE (single byte, via RESP_LO), and the sticky `tmo` flag is set.
  - If `dbg_ready` arrives in the terminal-count cycle, the access completes normally.
- Undefined: there is no counter, BUS waits indefinitely, and status bit1 always reads 0.

## Test plan
- Write: bytes 01 13 BE EF -> `dbg_we`=1, `dbg_a`=0x13, `dbg_di`=0xBEEF until ready (3-cycle delay) -> tx 0xA5.
- Read: bytes 02 10, responder returns 0x1234 with ready after 5 cycles -> tx 0x12 then 0x34; `tx_ready` held low for 4 cycles keeps 0x12 stable.
- Bad opcode 0x7F -> tx 0xEF, `busy` low next cycle, then a following 02 10 read works.
- Overrun: send 0x55 while in BUS -> byte ignored; then 03 -> tx 0x01; a second 03 -> tx 0x00.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): 02 05 with `dbg_ready` never high -> `dbg_rd` high for exactly 8 cycles, tx 0xEE, then 03 -> tx 0x02.
- Reset asserted mid-DHI and mid-BUS -> outputs 0 in the next cycle; a following 01 13 00 01 write completes with 0xA5.
